pipeline_hazard_controller: RTL and testbench

Central stall/flush sequencer for the five-stage pipeline. Decides each cycle whether the PC, the IF/ID pipeline register and the later stage registers advance, hold, or are cleared. Handles load-use hazards detected in ID, taken branches resolved in EX, and multi-cycle data-memory waits in MEM. Also keeps stall/flush statistics and a memory-wait watchdog.

---
 rtl/pipeline_ctrl_pkg.sv | 46 ++++
 rtl/load_use_detector.sv | 26 ++
 rtl/pipeline_hazard_controller.sv | 132 +++++++++++++
 tb/tb_pipeline_hazard_controller.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline hazard controller:
// FSM states, the zero register and the control bundle.
package pipeline_ctrl_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_e;

  localparam int REG_ZERO = 0;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_flush;
    logic pipe_write;
    logic memwb_bubble;
  } ctrl_t;

  localparam ctrl_t CTRL_RESET = '{
    pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b1,
    idex_flush: 1'b1, pipe_write: 1'b0, memwb_bubble: 1'b1
  };

  localparam ctrl_t CTRL_FREEZE = '{
    pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0,
    idex_flush: 1'b0, pipe_write: 1'b0, memwb_bubble: 1'b1
  };

  localparam ctrl_t CTRL_FLUSH = '{
    pc_write: 1'b1, ifid_write: 1'b0, ifid_flush: 1'b1,
    idex_flush: 1'b1, pipe_write: 1'b1, memwb_bubble: 1'b0
  };

  localparam ctrl_t CTRL_STALL = '{
    pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0,
    idex_flush: 1'b1, pipe_write: 1'b1, memwb_bubble: 1'b0
  };

  localparam ctrl_t CTRL_RUN = '{
    pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b0,
    idex_flush: 1'b0, pipe_write: 1'b1, memwb_bubble: 1'b0
  };

endpackage

// File: rtl/load_use_detector.sv
// Flags an ID-stage read of a register that the load in EX
// has not yet produced.
module load_use_detector
  import pipeline_ctrl_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      ex_mem_read,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rd,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs,
  input  logic [REG_ADDR_WIDTH-1:0] id_rt,
  input  logic                      id_uses_rs,
  input  logic                      id_uses_rt,
  output logic                      load_use
);

  logic rd_live;
  logic rs_hit;
  logic rt_hit;

  assign rd_live  = ex_rd != REG_ADDR_WIDTH'(REG_ZERO);
  assign rs_hit   = id_uses_rs & (id_rs == ex_rd);
  assign rt_hit   = id_uses_rt & (id_rt == ex_rd);
  assign load_use = ex_mem_read & rd_live & (rs_hit | rt_hit);

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the five-stage pipeline, with
// memory-wait watchdog and saturating stall/flush statistics.
module pipeline_hazard_controller
  import pipeline_ctrl_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH      = 32,
  parameter int MEM_TIMEOUT    = 1024
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs,
  input  logic [REG_ADDR_WIDTH-1:0] id_rt,
  input  logic                      id_uses_rs,
  input  logic                      id_uses_rt,
  input  logic                      ex_mem_read,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rd,
  input  logic                      ex_branch_taken,
  input  logic                      mem_req,
  input  logic                      mem_ready,
  output logic                      pc_write,
  output logic                      ifid_write,
  output logic                      ifid_flush,
  output logic                      idex_flush,
  output logic                      pipe_write,
  output logic                      memwb_bubble,
  output logic                      mem_timeout,
  output logic [CNT_WIDTH-1:0]      stall_cycles,
  output logic [CNT_WIDTH-1:0]      flush_count
);

  localparam int WW = $clog2(MEM_TIMEOUT) + 1;
  localparam logic [WW-1:0] WAIT_LIMIT = WW'(MEM_TIMEOUT - 1);

  logic           load_use;
  logic           mem_stall;
  ctrl_t          ctrl;

  state_e         state_q, state_d;
  logic [WW-1:0]  wait_q, wait_d;
  logic           timeout_q, timeout_d;
  logic [CNT_WIDTH-1:0] stall_q, stall_d;
  logic [CNT_WIDTH-1:0] flush_q, flush_d;

  load_use_detector #(
    .REG_ADDR_WIDTH(REG_ADDR_WIDTH)
  ) u_load_use (
    .ex_mem_read(ex_mem_read),
    .ex_rd      (ex_rd),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_uses_rs (id_uses_rs),
    .id_uses_rt (id_uses_rt),
    .load_use   (load_use)
  );

  assign mem_stall = mem_req & ~mem_ready;

  // Freeze outranks the branch so a taken branch is held, not lost.
  always_comb begin
    ctrl = CTRL_RUN;
    if (reset)
      ctrl = CTRL_RESET;
    else if (mem_stall)
      ctrl = CTRL_FREEZE;
    else if (ex_branch_taken)
      ctrl = CTRL_FLUSH;
    else if (load_use)
      ctrl = CTRL_STALL;
  end

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    timeout_d = timeout_q;
    unique case (state_q)
      RUN: begin
        if (mem_stall) begin
          state_d = MEM_WAIT;
          wait_d  = '0;
        end
      end
      MEM_WAIT: begin
        if (!mem_stall) begin
          state_d = RUN;
        end else begin
          if (wait_q != WAIT_LIMIT)
            wait_d = wait_q + 1'b1;
          if (wait_d == WAIT_LIMIT)
            timeout_d = 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (!ctrl.pc_write && stall_q != '1)
      stall_d = stall_q + 1'b1;
    if (!mem_stall && ex_branch_taken && flush_q != '1)
      flush_d = flush_q + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= RUN;
      wait_q    <= '0;
      timeout_q <= 1'b0;
      stall_q   <= '0;
      flush_q   <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      timeout_q <= timeout_d;
      stall_q   <= stall_d;
      flush_q   <= flush_d;
    end
  end

  assign pc_write     = ctrl.pc_write;
  assign ifid_write   = ctrl.ifid_write;
  assign ifid_flush   = ctrl.ifid_flush;
  assign idex_flush   = ctrl.idex_flush;
  assign pipe_write   = ctrl.pipe_write;
  assign memwb_bubble = ctrl.memwb_bubble;
  assign mem_timeout  = timeout_q;
  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed vector bench for pipeline_hazard_controller.
module tb_pipeline_hazard_controller;

  localparam logic [5:0] C_RST = 6'b001101;
  localparam logic [5:0] C_FRZ = 6'b000001;
  localparam logic [5:0] C_FLS = 6'b101110;
  localparam logic [5:0] C_STL = 6'b000110;
  localparam logic [5:0] C_RUN = 6'b110010;

  typedef struct {
    logic       rst;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urs;
    logic       urt;
    logic       mr;
    logic [4:0] rd;
    logic       br;
    logic       req;
    logic       rdy;
    logic [5:0] ctrl;
    logic       to;
    int         s;
    int         f;
  } vec_t;

  logic       clock = 1'b0;
  logic       reset;
  logic [4:0] id_rs, id_rt, ex_rd;
  logic       id_uses_rs, id_uses_rt, ex_mem_read;
  logic       ex_branch_taken, mem_req, mem_ready;
  logic       pc_write, ifid_write, ifid_flush;
  logic       idex_flush, pipe_write, memwb_bubble;
  logic       mem_timeout;
  logic [31:0] stall_cycles, flush_count;

  logic       s_pc, s_ifw, s_iff, s_idf, s_pw, s_mb, s_to;
  logic [1:0] s_stall, s_flush;

  int checks = 0;
  int failures = 0;
  vec_t tbl[$];

  always #5 clock = ~clock;

  pipeline_hazard_controller #(
    .REG_ADDR_WIDTH(5), .CNT_WIDTH(32), .MEM_TIMEOUT(4)
  ) dut (
    .clock(clock), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_write(pc_write), .ifid_write(ifid_write),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .pipe_write(pipe_write), .memwb_bubble(memwb_bubble),
    .mem_timeout(mem_timeout),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  pipeline_hazard_controller #(
    .REG_ADDR_WIDTH(5), .CNT_WIDTH(2), .MEM_TIMEOUT(4)
  ) dut_sat (
    .clock(clock), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_write(s_pc), .ifid_write(s_ifw),
    .ifid_flush(s_iff), .idex_flush(s_idf),
    .pipe_write(s_pw), .memwb_bubble(s_mb),
    .mem_timeout(s_to),
    .stall_cycles(s_stall), .flush_count(s_flush)
  );

  function automatic vec_t mk(
    input logic rst, input logic [4:0] rs, input logic [4:0] rt,
    input logic urs, input logic urt, input logic mr,
    input logic [4:0] rd, input logic br, input logic req,
    input logic rdy, input logic [5:0] ctrl, input logic to,
    input int s, input int f);
    vec_t v;
    v.rst = rst; v.rs = rs; v.rt = rt; v.urs = urs; v.urt = urt;
    v.mr = mr; v.rd = rd; v.br = br; v.req = req; v.rdy = rdy;
    v.ctrl = ctrl; v.to = to; v.s = s; v.f = f;
    return v;
  endfunction

  function automatic vec_t mw(
    input logic rst, input logic br, input logic req,
    input logic rdy, input logic [5:0] ctrl, input logic to,
    input int s, input int f);
    return mk(rst, 0, 0, 0, 0, 0, 0, br, req, rdy, ctrl, to, s, f);
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic run_row(input string tag, input vec_t v);
    reset           = v.rst;
    id_rs           = v.rs;
    id_rt           = v.rt;
    id_uses_rs      = v.urs;
    id_uses_rt      = v.urt;
    ex_mem_read     = v.mr;
    ex_rd           = v.rd;
    ex_branch_taken = v.br;
    mem_req         = v.req;
    mem_ready       = v.rdy;
    #3;
    chk({tag, ".ctrl"}, 32'({pc_write, ifid_write, ifid_flush,
                             idex_flush, pipe_write, memwb_bubble}),
        32'(v.ctrl));
    chk({tag, ".timeout"}, 32'(mem_timeout), 32'(v.to));
    chk({tag, ".stall"}, stall_cycles, v.s);
    chk({tag, ".flush"}, flush_count, v.f);
    @(posedge clock);
    #1;
  endtask

  initial begin
    // r0..r9: load-use and branch flush
    tbl.push_back(mw(1, 0, 0, 0, C_RST, 0, 0, 0));
    tbl.push_back(mw(0, 0, 0, 0, C_RUN, 0, 0, 0));
    tbl.push_back(mk(0, 8, 0, 1, 0, 1, 8, 0, 0, 0, C_STL, 0, 0, 0));
    tbl.push_back(mw(0, 0, 0, 0, C_RUN, 0, 1, 0));
    tbl.push_back(mk(0, 5, 5, 0, 1, 1, 5, 0, 0, 0, C_STL, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1, 1, 0, 0, 0, 0, C_RUN, 0, 2, 0));
    tbl.push_back(mk(0, 9, 9, 0, 0, 1, 9, 0, 0, 0, C_RUN, 0, 2, 0));
    tbl.push_back(mk(0, 8, 0, 1, 0, 0, 8, 0, 0, 0, C_RUN, 0, 2, 0));
    tbl.push_back(mk(0, 8, 0, 1, 0, 1, 8, 1, 0, 0, C_FLS, 0, 2, 0));
    tbl.push_back(mw(0, 0, 0, 0, C_RUN, 0, 2, 1));
    // r10..r15: three-cycle memory wait
    tbl.push_back(mw(0, 0, 1, 0, C_FRZ, 0, 2, 1));
    tbl.push_back(mw(0, 0, 1, 0, C_FRZ, 0, 3, 1));
    tbl.push_back(mw(0, 0, 1, 0, C_FRZ, 0, 4, 1));
    tbl.push_back(mw(0, 0, 1, 1, C_RUN, 0, 5, 1));
    tbl.push_back(mw(0, 0, 0, 0, C_RUN, 0, 5, 1));
    tbl.push_back(mw(0, 0, 1, 1, C_RUN, 0, 5, 1));
    // r16..r19: branch held through a two-cycle freeze
    tbl.push_back(mw(0, 1, 1, 0, C_FRZ, 0, 5, 1));
    tbl.push_back(mw(0, 1, 1, 0, C_FRZ, 0, 6, 1));
    tbl.push_back(mw(0, 1, 1, 1, C_FLS, 0, 7, 1));
    tbl.push_back(mw(0, 0, 0, 0, C_RUN, 0, 7, 2));
    // r20..r22: load-use deferred across a freeze
    tbl.push_back(mk(0, 8, 0, 1, 0, 1, 8, 0, 1, 0, C_FRZ, 0, 7, 2));
    tbl.push_back(mk(0, 8, 0, 1, 0, 1, 8, 0, 1, 1, C_STL, 0, 8, 2));
    tbl.push_back(mw(0, 0, 0, 0, C_RUN, 0, 9, 2));
    // r23..r25: back-to-back branches
    tbl.push_back(mw(0, 1, 0, 0, C_FLS, 0, 9, 2));
    tbl.push_back(mw(0, 1, 0, 0, C_FLS, 0, 9, 3));
    tbl.push_back(mw(0, 0, 0, 0, C_RUN, 0, 9, 4));

    reset = 1'b1;
    id_rs = '0; id_rt = '0; ex_rd = '0;
    id_uses_rs = 0; id_uses_rt = 0; ex_mem_read = 0;
    ex_branch_taken = 0; mem_req = 0; mem_ready = 0;
    @(posedge clock);
    #1;

    foreach (tbl[i])
      run_row($sformatf("row%0d", i), tbl[i]);

    chk("sat.stall", 32'(s_stall), 32'd3);
    chk("sat.flush", 32'(s_flush), 32'd3);

    // Watchdog: six wait cycles with MEM_TIMEOUT=4
    for (int i = 0; i < 6; i++)
      run_row($sformatf("wd%0d", i + 1),
              mw(0, 0, 1, 0, C_FRZ, (i >= 4), 9 + i, 4));
    run_row("wd_ready", mw(0, 0, 1, 1, C_RUN, 1, 15, 4));
    run_row("wd_idle", mw(0, 0, 0, 0, C_RUN, 1, 15, 4));

    // Reset in the second cycle of a wait
    run_row("rw_w1", mw(0, 0, 1, 0, C_FRZ, 1, 15, 4));
    run_row("rw_rst", mw(1, 0, 1, 0, C_RST, 1, 16, 4));
    for (int i = 0; i < 5; i++)
      run_row($sformatf("rw_a%0d", i),
              mw(0, 0, 1, 0, C_FRZ, (i == 4), i, 0));
    run_row("rw_ready", mw(0, 0, 1, 1, C_RUN, 1, 5, 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
